// File: rtl/sensores_pkg.sv
// Constants and types shared by the MPU6050 sensor consumers
// (step detector and gyroscope controller).
package sensores_pkg;

  localparam int          DATA_WIDTH = 16;
  localparam int          MAG_WIDTH  = 18;
  // L1 magnitude of a resting sensor in the +-2 g range: 1 g = 16384 LSB
  localparam int unsigned GRAVEDAD   = 16384;

  typedef enum logic [1:0] {
    REPOSO = 2'd0,
    PICO   = 2'd1,
    ARMADO = 2'd2
  } estado_t;

endpackage

// File: rtl/detector_pasos_if.sv
// Sample bus from the MPU6050 controller into the step detector.
// Handshake: muestra_valida is a one-cycle strobe qualifying accel_x/y/z in
// that same cycle; there is no ready, so the consumer accepts every strobe.
interface detector_pasos_if
  import sensores_pkg::*;
#(
  parameter int DW = DATA_WIDTH
) ();

  logic                 muestra_valida;
  logic signed [DW-1:0] accel_x;
  logic signed [DW-1:0] accel_y;
  logic signed [DW-1:0] accel_z;

  modport master (output muestra_valida, output accel_x, output accel_y, output accel_z);
  modport slave  (input  muestra_valida, input  accel_x, input  accel_y, input  accel_z);

endinterface

// File: rtl/magnitud_l1.sv
// Two-stage pipeline: saturating |x|,|y|,|z|, then dyn = | |x|+|y|+|z| - GRAV |.
// Generic in width and rest magnitude so it also serves gyro data.
module magnitud_l1
  import sensores_pkg::*;
#(
  parameter int          DW   = DATA_WIDTH,
  parameter int          MW   = MAG_WIDTH,
  parameter int unsigned GRAV = GRAVEDAD
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 vaciar,
  input  logic                 valida_in,
  input  logic signed [DW-1:0] x_in,
  input  logic signed [DW-1:0] y_in,
  input  logic signed [DW-1:0] z_in,
  output logic                 valida_out,
  output logic [MW-1:0]        dyn_out
);

  localparam logic [DW-1:0] MAX_POS = {1'b0, {(DW-1){1'b1}}};
  localparam logic [DW-1:0] MIN_NEG = {1'b1, {(DW-1){1'b0}}};
  localparam logic [MW-1:0] GRAV_M  = MW'(GRAV);

  // The most negative code has no positive twin; clamp it to the max.
  function automatic logic [DW-1:0] abs_sat(input logic [DW-1:0] v);
    if (!v[DW-1]) return v;
    if (v == MIN_NEG) return MAX_POS;
    return ~v + DW'(1);
  endfunction

  logic          v1_q, v1_d, v2_q, v2_d;
  logic [DW-1:0] ax_q, ax_d, ay_q, ay_d, az_q, az_d;
  logic [MW-1:0] l1;
  logic [MW-1:0] dyn_q, dyn_d;

  always_comb begin
    v1_d  = valida_in & ~vaciar;
    ax_d  = ax_q;
    ay_d  = ay_q;
    az_d  = az_q;
    if (v1_d) begin
      ax_d = abs_sat(x_in);
      ay_d = abs_sat(y_in);
      az_d = abs_sat(z_in);
    end
    l1    = MW'(ax_q) + MW'(ay_q) + MW'(az_q);
    v2_d  = v1_q & ~vaciar;
    dyn_d = dyn_q;
    if (v2_d) dyn_d = (l1 >= GRAV_M) ? (l1 - GRAV_M) : (GRAV_M - l1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      v1_q  <= 1'b0;
      v2_q  <= 1'b0;
      ax_q  <= '0;
      ay_q  <= '0;
      az_q  <= '0;
      dyn_q <= '0;
    end else begin
      v1_q  <= v1_d;
      v2_q  <= v2_d;
      ax_q  <= ax_d;
      ay_q  <= ay_d;
      az_q  <= az_d;
      dyn_q <= dyn_d;
    end
  end

  assign valida_out = v2_q;
  assign dyn_out    = dyn_q;

endmodule

// File: rtl/detector_pasos.sv
// Step detector: gravity-removed L1 magnitude feeds a peak/valley FSM that
// emits per-step pulses, a saturating step count and the walking level.
module detector_pasos
  import sensores_pkg::*;
#(
  parameter int          DATA_WIDTH  = sensores_pkg::DATA_WIDTH,
  parameter int unsigned GRAVEDAD    = sensores_pkg::GRAVEDAD,
  parameter int          UMBRAL_ALTO = 4000,
  parameter int          UMBRAL_BAJO = 1500,
  parameter int          MIN_SEP     = 4,
  parameter int          VENTANA     = 20,
  parameter int          CNT_WIDTH   = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 habilitar,
  input  logic                 limpiar_conteo,
  detector_pasos_if.slave      bus,
  output logic                 paso,
  output logic                 caminar,
  output logic [CNT_WIDTH-1:0] conteo_pasos,
  output estado_t              estado_dbg,
  output logic                 decision_valida,
  output logic [MAG_WIDTH-1:0] dyn_dbg
);

  localparam int                   SEP_W   = $clog2(VENTANA + 1);
  localparam logic [SEP_W-1:0]     SEP_MAX = SEP_W'(VENTANA);
  localparam logic [SEP_W-1:0]     SEP_MIN = SEP_W'(MIN_SEP);
  localparam logic [MAG_WIDTH-1:0] ALTO    = MAG_WIDTH'(UMBRAL_ALTO);
  localparam logic [MAG_WIDTH-1:0] BAJO    = MAG_WIDTH'(UMBRAL_BAJO);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  logic                 v2;
  logic [MAG_WIDTH-1:0] dyn2;

  magnitud_l1 #(
    .DW   (DATA_WIDTH),
    .MW   (MAG_WIDTH),
    .GRAV (GRAVEDAD)
  ) u_magnitud (
    .clk        (clk),
    .reset      (reset),
    .vaciar     (!habilitar),
    .valida_in  (bus.muestra_valida),
    .x_in       (bus.accel_x),
    .y_in       (bus.accel_y),
    .z_in       (bus.accel_z),
    .valida_out (v2),
    .dyn_out    (dyn2)
  );

  estado_t              estado_q, estado_d;
  logic [SEP_W-1:0]     sep_q, sep_d, sep_inc;
  logic                 paso_q, paso_d, caminar_q, caminar_d, dec_q, dec_d;
  logic [CNT_WIDTH-1:0] conteo_q, conteo_d;
  logic [MAG_WIDTH-1:0] dyn_q, dyn_d;
  logic                 acepta;

  always_comb begin
    estado_d  = estado_q;
    sep_d     = sep_q;
    paso_d    = 1'b0;
    caminar_d = caminar_q;
    conteo_d  = conteo_q;
    dec_d     = 1'b0;
    dyn_d     = dyn_q;
    acepta    = 1'b0;
    sep_inc   = (sep_q == SEP_MAX) ? SEP_MAX : sep_q + SEP_W'(1);

    if (!habilitar) begin
      estado_d  = REPOSO;
      sep_d     = SEP_MAX;
      caminar_d = 1'b0;
    end else if (v2) begin
      dec_d = 1'b1;
      dyn_d = dyn2;
      sep_d = sep_inc;
      unique case (estado_q)
        REPOSO: if (dyn2 > ALTO) estado_d = PICO;
        PICO: if (dyn2 < BAJO) begin
          estado_d = ARMADO;
          acepta   = (sep_q >= SEP_MIN);
        end
        ARMADO: begin
          if (dyn2 > ALTO)              estado_d = PICO;
          else if (sep_inc == SEP_MAX)  estado_d = REPOSO;
        end
        default: estado_d = REPOSO;
      endcase

      // sep_q still holds the distance to the previous accepted step here
      if (acepta) begin
        paso_d = 1'b1;
        sep_d  = '0;
        if (sep_q < SEP_MAX)      caminar_d = 1'b1;
        if (conteo_q != CNT_MAX)  conteo_d  = conteo_q + CNT_WIDTH'(1);
      end else if (sep_inc == SEP_MAX) begin
        caminar_d = 1'b0;
      end
      if (estado_d == REPOSO) caminar_d = 1'b0;
    end

    if (limpiar_conteo) conteo_d = '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      estado_q  <= REPOSO;
      sep_q     <= SEP_MAX;
      paso_q    <= 1'b0;
      caminar_q <= 1'b0;
      conteo_q  <= '0;
      dec_q     <= 1'b0;
      dyn_q     <= '0;
    end else begin
      estado_q  <= estado_d;
      sep_q     <= sep_d;
      paso_q    <= paso_d;
      caminar_q <= caminar_d;
      conteo_q  <= conteo_d;
      dec_q     <= dec_d;
      dyn_q     <= dyn_d;
    end
  end

  assign paso            = paso_q;
  assign caminar         = caminar_q;
  assign conteo_pasos    = conteo_q;
  assign estado_dbg      = estado_q;
  assign decision_valida = dec_q;
  assign dyn_dbg         = dyn_q;

endmodule

// File: tb/tb_detector_pasos.sv
// Directed-vector bench for detector_pasos: drivers push expected per-sample
// decisions into a queue, a negedge monitor pops and compares them.
module tb_detector_pasos;
  import sensores_pkg::*;

  localparam int EW = 30;  // {paso, caminar, conteo[7:0], estado[1:0], dyn[17:0]}
  localparam int IW = 12;  // {paso, caminar, conteo[7:0], estado[1:0]}

  logic clk = 1'b0;
  logic reset;
  logic habilitar;
  logic limpiar;
  logic paso, caminar, decision_valida;
  logic [7:0]  conteo_pasos;
  estado_t     estado_dbg;
  logic [17:0] dyn_dbg;

  detector_pasos_if bus ();

  detector_pasos dut (
    .clk             (clk),
    .reset           (reset),
    .habilitar       (habilitar),
    .limpiar_conteo  (limpiar),
    .bus             (bus),
    .paso            (paso),
    .caminar         (caminar),
    .conteo_pasos    (conteo_pasos),
    .estado_dbg      (estado_dbg),
    .decision_valida (decision_valida),
    .dyn_dbg         (dyn_dbg)
  );

  // ---------------- clock / reset ----------------
  always #10 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  logic [EW-1:0] exp_q[$];
  int            lat_q[$];
  logic [IW-1:0] idle_exp;
  logic          chk_idle = 1'b0;
  logic          drain_to = 1'b0;
  logic          drain_seen = 1'b0;
  int            n_vec = 0;
  int            n_fail = 0;

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [EW-1:0] e, got;
    logic [IW-1:0] got_i;
    int            t;
    if (drain_to && !drain_seen) begin
      n_fail++;
      drain_seen = 1'b1;
      $display("FAIL drain_timeout: %0d decisions still pending, required 0", exp_q.size());
    end
    if (chk_idle) begin
      got_i = {paso, caminar, conteo_pasos, estado_dbg};
      n_vec++;
      if (got_i !== idle_exp) begin
        n_fail++;
        $display("FAIL idle_outputs cyc=%0d {paso,cam,cnt,est} got=%h required=%h", cyc, got_i, idle_exp);
      end
    end else if (reset && decision_valida) begin
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_decision cyc=%0d paso=%b cnt=%0d, required none", cyc, paso, conteo_pasos);
      end else begin
        e   = exp_q.pop_front();
        t   = lat_q.pop_front();
        got = {paso, caminar, conteo_pasos, estado_dbg, dyn_dbg};
        n_vec++;
        if (got !== e || cyc != t + 3) begin
          n_fail++;
          $display("FAIL decision {paso,cam,cnt,est,dyn} got=%h at cyc %0d, required=%h at cyc %0d",
                   got, cyc, e, t + 3);
        end
      end
    end else if (paso !== 1'b0) begin
      n_fail++;
      $display("FAIL stray_paso cyc=%0d paso=%b, required 0", cyc, paso);
    end
  end

  // ---------------- driver tasks ----------------
  // Called at a negedge; returns at a negedge. A zero gap gives back-to-back strobes.
  task automatic smp(input logic signed [15:0] x, input logic signed [15:0] y,
                     input logic signed [15:0] z, input logic [17:0] e_dyn,
                     input logic e_paso, input logic e_cam, input logic [7:0] e_cnt,
                     input estado_t e_est, input logic clr);
    bus.muestra_valida = 1'b1;
    bus.accel_x = x;
    bus.accel_y = y;
    bus.accel_z = z;
    exp_q.push_back({e_paso, e_cam, e_cnt, e_est, e_dyn});
    lat_q.push_back(cyc);
    @(negedge clk);
    bus.muestra_valida = 1'b0;
    if (clr) begin
      @(negedge clk);
      limpiar = 1'b1;
      @(negedge clk);
      limpiar = 1'b0;
    end else begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
  endtask

  task automatic rest(input logic p, input logic c, input logic [7:0] n, input estado_t s);
    smp(16'sd0, 16'sd0, 16'sd16384, 18'd0, p, c, n, s, 1'b0);
  endtask

  task automatic peak(input logic p, input logic c, input logic [7:0] n, input estado_t s);
    smp(16'sd0, 16'sd0, 16'sd22000, 18'd5616, p, c, n, s, 1'b0);
  endtask

  task automatic mid(input logic p, input logic c, input logic [7:0] n, input estado_t s);
    smp(16'sd0, 16'sd0, 16'sd19000, 18'd2616, p, c, n, s, 1'b0);
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (exp_q.size() != 0) begin
      drain_to = 1'b1;
      @(negedge clk);
      @(negedge clk);
      exp_q.delete();
      lat_q.delete();
      drain_to = 1'b0;
      drain_seen = 1'b0;
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic       c_prev, c_now;
    logic [7:0] n_prev, n_now;
    reset = 1'b0;
    habilitar = 1'b1;
    limpiar = 1'b0;
    bus.muestra_valida = 1'b0;
    bus.accel_x = '0;
    bus.accel_y = '0;
    bus.accel_z = '0;

    // Reset held with strobes active, then released
    @(negedge clk);
    idle_exp = {1'b0, 1'b0, 8'd0, REPOSO};
    chk_idle = 1'b1;
    bus.accel_z = 16'sd22000;
    repeat (5) begin
      bus.muestra_valida = 1'b1;
      @(negedge clk);
    end
    bus.muestra_valida = 1'b0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk_idle = 1'b0;

    // Rest
    for (int i = 0; i < 30; i++) rest(0, 0, 8'd0, REPOSO);

    // Single step, then the walking window expires
    peak(0, 0, 8'd0, PICO);
    rest(1, 0, 8'd1, ARMADO);
    for (int i = 0; i < 19; i++) rest(0, 0, 8'd1, ARMADO);
    rest(0, 0, 8'd1, REPOSO);

    // Walking: three steps 8 samples apart
    peak(0, 0, 8'd1, PICO);
    rest(1, 0, 8'd2, ARMADO);
    for (int i = 0; i < 6; i++) rest(0, 0, 8'd2, ARMADO);
    peak(0, 0, 8'd2, PICO);
    rest(1, 1, 8'd3, ARMADO);
    for (int i = 0; i < 6; i++) rest(0, 1, 8'd3, ARMADO);
    peak(0, 1, 8'd3, PICO);
    rest(1, 1, 8'd4, ARMADO);
    for (int i = 0; i < 19; i++) rest(0, 1, 8'd4, ARMADO);
    rest(0, 0, 8'd4, REPOSO);

    // Rejection of a close peak, then acceptance at exactly MIN_SEP through hysteresis
    peak(0, 0, 8'd4, PICO);
    rest(1, 0, 8'd5, ARMADO);
    rest(0, 0, 8'd5, ARMADO);
    rest(0, 0, 8'd5, ARMADO);
    peak(0, 0, 8'd5, PICO);
    rest(0, 0, 8'd5, ARMADO);
    peak(0, 0, 8'd5, PICO);
    rest(1, 1, 8'd6, ARMADO);
    rest(0, 1, 8'd6, ARMADO);
    rest(0, 1, 8'd6, ARMADO);
    peak(0, 1, 8'd6, PICO);
    mid(0, 1, 8'd6, PICO);
    rest(1, 1, 8'd7, ARMADO);

    // Clear coincident with an accepted step
    for (int i = 0; i < 3; i++) rest(0, 1, 8'd7, ARMADO);
    peak(0, 1, 8'd7, PICO);
    smp(16'sd0, 16'sd0, 16'sd16384, 18'd0, 1, 1, 8'd0, ARMADO, 1'b1);

    // Most negative x saturates
    smp(-16'sd32768, 16'sd0, 16'sd0, 18'd16383, 0, 1, 8'd0, PICO, 1'b0);
    rest(0, 1, 8'd0, ARMADO);
    peak(0, 1, 8'd0, PICO);
    mid(0, 1, 8'd0, PICO);
    rest(1, 1, 8'd1, ARMADO);

    // Disable: FSM idle, count holds, samples ignored
    drain();
    habilitar = 1'b0;
    @(negedge clk);
    idle_exp = {1'b0, 1'b0, 8'd1, REPOSO};
    chk_idle = 1'b1;
    bus.muestra_valida = 1'b1;
    bus.accel_z = 16'sd22000;
    @(negedge clk);
    bus.muestra_valida = 1'b0;
    repeat (4) @(negedge clk);
    chk_idle = 1'b0;
    habilitar = 1'b1;
    peak(0, 0, 8'd1, PICO);
    rest(1, 0, 8'd2, ARMADO);

    // Reset while a completing sample is in flight
    for (int i = 0; i < 3; i++) rest(0, 0, 8'd2, ARMADO);
    peak(0, 0, 8'd2, PICO);
    drain();
    bus.muestra_valida = 1'b1;
    bus.accel_z = 16'sd16384;
    @(negedge clk);
    bus.muestra_valida = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    idle_exp = {1'b0, 1'b0, 8'd0, REPOSO};
    chk_idle = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (6) @(negedge clk);
    chk_idle = 1'b0;

    // Counter saturation at 255
    for (int k = 1; k <= 256; k++) begin
      c_prev = (k >= 3);
      c_now  = (k >= 2);
      n_prev = (k - 1 > 255) ? 8'd255 : 8'(k - 1);
      n_now  = (k > 255) ? 8'd255 : 8'(k);
      peak(0, c_prev, n_prev, PICO);
      rest(1, c_now, n_now, ARMADO);
      repeat (3) rest(0, c_now, n_now, ARMADO);
    end

    drain();
    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
